// File: rtl/me_window_loader.sv
// Motion-estimation window loader: stores one macroblock and its search window from a raster
// byte stream into column-banked memories, kicks the me core, then serves per-row reads.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | nothing loaded, waiting for load_start
// S_LOAD_CUR  | accepting MACRO_DIM*MACRO_DIM current-block pixels
// S_LOAD_SRCH | accepting SEARCH_DIM*SEARCH_DIM search-window pixels
// S_KICK      | one-cycle me_start pulse
// S_SERVE     | window valid for reads; load_start begins a new load
module me_window_loader #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic [7:0]                   pix_in,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [5:0]                   addr,
    input  logic [5:0]                   amt,
    output logic [MACRO_DIM*8-1:0]       pixel_cpr_out,
    output logic [(MACRO_DIM+1)*8-1:0]   pixel_spr_out,
    output logic                         me_start,
    output logic                         win_ready
);
    localparam int NB     = MACRO_DIM + 1;
    localparam int NBAND  = (SEARCH_DIM + NB - 1) / NB;
    localparam int SDEPTH = NBAND * SEARCH_DIM;
    localparam int CDW    = $clog2(MACRO_DIM);
    localparam int BW     = $clog2(NB);
    localparam int SAW    = $clog2(SDEPTH);
    localparam int CW     = $clog2(64 + NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CUR,
        S_LOAD_SRCH,
        S_KICK,
        S_SERVE
    } state_t;

    state_t         state_q;
    logic [5:0]     x_q;
    logic [5:0]     y_q;
    logic [BW-1:0]  sbank_q;
    logic [SAW-1:0] sbase_q;
    logic           pix_ready_q;
    logic           me_start_q;
    logic           win_ready_q;
    logic           xfer;

    assign xfer = pix_valid && pix_ready_q;

    // sbank_q/sbase_q track (x mod NB) and (x div NB)*SEARCH_DIM incrementally, avoiding a divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sbank_q     <= '0;
            sbase_q     <= '0;
            pix_ready_q <= 1'b0;
            me_start_q  <= 1'b0;
            win_ready_q <= 1'b0;
        end else begin
            me_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        state_q     <= S_LOAD_CUR;
                        pix_ready_q <= 1'b1;
                        x_q         <= '0;
                        y_q         <= '0;
                    end
                end
                S_LOAD_CUR: begin
                    if (xfer) begin
                        if (x_q == 6'(MACRO_DIM - 1)) begin
                            x_q <= '0;
                            if (y_q == 6'(MACRO_DIM - 1)) begin
                                y_q     <= '0;
                                sbank_q <= '0;
                                sbase_q <= '0;
                                state_q <= S_LOAD_SRCH;
                            end else begin
                                y_q <= y_q + 6'd1;
                            end
                        end else begin
                            x_q <= x_q + 6'd1;
                        end
                    end
                end
                S_LOAD_SRCH: begin
                    if (xfer) begin
                        if (x_q == 6'(SEARCH_DIM - 1)) begin
                            x_q     <= '0;
                            sbank_q <= '0;
                            sbase_q <= '0;
                            if (y_q == 6'(SEARCH_DIM - 1)) begin
                                y_q         <= '0;
                                state_q     <= S_KICK;
                                pix_ready_q <= 1'b0;
                                me_start_q  <= 1'b1;
                            end else begin
                                y_q <= y_q + 6'd1;
                            end
                        end else begin
                            x_q <= x_q + 6'd1;
                            if (sbank_q == BW'(NB - 1)) begin
                                sbank_q <= '0;
                                sbase_q <= sbase_q + SAW'(SEARCH_DIM);
                            end else begin
                                sbank_q <= sbank_q + BW'(1);
                            end
                        end
                    end
                end
                S_KICK: begin
                    state_q     <= S_SERVE;
                    win_ready_q <= 1'b1;
                end
                S_SERVE: begin
                    if (load_start) begin
                        state_q     <= S_LOAD_CUR;
                        win_ready_q <= 1'b0;
                        pix_ready_q <= 1'b1;
                        x_q         <= '0;
                        y_q         <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [7:0] cur_mem  [MACRO_DIM][MACRO_DIM];
    logic [7:0] srch_mem [NB][SDEPTH];
    logic       cur_we;
    logic       srch_we;

    assign cur_we  = xfer && (state_q == S_LOAD_CUR);
    assign srch_we = xfer && (state_q == S_LOAD_SRCH);

    always_ff @(posedge clk) begin
        if (cur_we) begin
            cur_mem[x_q[CDW-1:0]][y_q[CDW-1:0]] <= pix_in;
        end
        if (srch_we) begin
            srch_mem[sbank_q][sbase_q + SAW'(y_q)] <= pix_in;
        end
    end

    logic [MACRO_DIM*8-1:0]     cpr_d;
    logic [(MACRO_DIM+1)*8-1:0] spr_d;
    logic                       addr_in_cur;
    logic                       addr_in_srch;

    assign addr_in_cur  = addr < 6'(MACRO_DIM);
    assign addr_in_srch = addr < 6'(SEARCH_DIM);

    for (genvar l = 0; l < MACRO_DIM; l++) begin : g_cpr
        assign cpr_d[l*8 +: 8] = addr_in_cur ? cur_mem[l][addr[CDW-1:0]] : 8'd0;
    end

    // Consecutive columns land in consecutive banks, so the NB lanes rotate over distinct banks
    for (genvar l = 0; l <= MACRO_DIM; l++) begin : g_spr
        logic [CW-1:0]  col;
        logic [BW-1:0]  bank;
        logic [SAW-1:0] ridx;
        assign col  = CW'(amt) + CW'(l);
        assign bank = BW'(col % CW'(NB));
        assign ridx = SAW'(col / CW'(NB)) * SAW'(SEARCH_DIM) + SAW'(addr);
        assign spr_d[l*8 +: 8] = (addr_in_srch && (col < CW'(SEARCH_DIM))) ?
                                 srch_mem[bank][ridx] : 8'd0;
    end

    logic [MACRO_DIM*8-1:0]     cpr_q;
    logic [(MACRO_DIM+1)*8-1:0] spr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpr_q <= '0;
            spr_q <= '0;
        end else begin
            cpr_q <= cpr_d;
            spr_q <= spr_d;
        end
    end

    assign pix_ready     = pix_ready_q;
    assign me_start      = me_start_q;
    assign win_ready     = win_ready_q;
    assign pixel_cpr_out = cpr_q;
    assign pixel_spr_out = spr_q;

endmodule

// File: tb/tb_me_window_loader.sv
// Bench for me_window_loader: streams windows in, checks handshake/kick timing and compares
// every read lane against a [row][column] picture of the loaded window.
module tb_me_window_loader;
    localparam int MD   = 16;
    localparam int SD   = 48;
    localparam int NCUR = MD * MD;
    localparam int NTOT = NCUR + SD * SD;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                load_start = 1'b0;
    logic [7:0]          pix_in = 8'd0;
    logic                pix_valid = 1'b0;
    logic                pix_ready;
    logic [5:0]          addr = 6'd0;
    logic [5:0]          amt = 6'd0;
    logic [MD*8-1:0]     cpr;
    logic [(MD+1)*8-1:0] spr;
    logic                me_start;
    logic                win_ready;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mcur  [MD][MD];
    logic [7:0] msrch [SD][SD];

    me_window_loader #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .addr(addr), .amt(amt),
        .pixel_cpr_out(cpr), .pixel_spr_out(spr), .me_start(me_start), .win_ready(win_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cpr(input int a, input int l);
        return (a < MD) ? mcur[a][l] : 8'd0;
    endfunction

    function automatic logic [7:0] exp_spr(input int a, input int s, input int l);
        int c;
        c = s + l;
        return (a < SD && c < SD) ? msrch[a][c] : 8'd0;
    endfunction

    // Drives one load; records model contents as pixels are offered and reports timing stats.
    task automatic run_load(input bit toggle, input bit pattern, input bit poke, input int stop_after,
                            output logic first_ready, output logic first_wr,
                            output int starts, output int start_at, output bit timeout);
        int n, cyc, yy, xx, m;
        bit ph, acc;
        logic [7:0] v;
        @(posedge clk); #1;
        load_start = 1'b1;
        pix_valid  = 1'b0;
        @(posedge clk); #1;
        load_start  = 1'b0;
        first_ready = pix_ready;
        first_wr    = win_ready;
        n = 0; cyc = 0; starts = 0; start_at = -1; ph = 1'b1; timeout = 1'b0;
        while (n < stop_after) begin
            if (cyc >= 4 * NTOT) begin
                timeout = 1'b1;
                break;
            end
            pix_valid  = toggle ? ph : 1'b1;
            ph         = !ph;
            load_start = poke && (cyc == 101 || cyc == 3001);
            if (pix_valid) begin
                if (n < NCUR) begin
                    yy = n / MD; xx = n % MD;
                    v = pattern ? 8'(yy * MD + xx) : 8'($urandom);
                    mcur[yy][xx] = v;
                end else begin
                    m = n - NCUR; yy = m / SD; xx = m % SD;
                    v = pattern ? 8'(yy * SD + xx) : 8'($urandom);
                    msrch[yy][xx] = v;
                end
                pix_in = v;
            end else begin
                pix_in = 8'($urandom);
            end
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) n++;
            if (me_start) begin
                starts++;
                start_at = n;
            end
            cyc++;
        end
        pix_valid  = 1'b0;
        load_start = 1'b0;
        if (stop_after >= NTOT) begin
            repeat (5) begin
                @(posedge clk); #1;
                if (me_start) begin
                    starts++;
                    start_at = n;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL rst_pix_ready got=%0b exp=0", pix_ready); end
        vectors++; if (me_start !== 1'b0) begin miscompares++; $display("FAIL rst_me_start got=%0b exp=0", me_start); end
        vectors++; if (win_ready !== 1'b0) begin miscompares++; $display("FAIL rst_win_ready got=%0b exp=0", win_ready); end
        vectors++; if (cpr !== '0) begin miscompares++; $display("FAIL rst_cpr got=%0h exp=0", cpr); end
        vectors++; if (spr !== '0) begin miscompares++; $display("FAIL rst_spr got=%0h exp=0", spr); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL idle_pix_ready got=%0b exp=0", pix_ready); end
    endtask

    task automatic test_load(input string tag, input bit toggle, input bit pattern, input bit poke);
        logic fr, fw;
        int starts, start_at;
        bit tmo;
        run_load(toggle, pattern, poke, NTOT, fr, fw, starts, start_at, tmo);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL %s timeout got=1 exp=0", tag); end
        vectors++; if (fr !== 1'b1) begin miscompares++; $display("FAIL %s first_pix_ready got=%0b exp=1", tag, fr); end
        vectors++; if (fw !== 1'b0) begin miscompares++; $display("FAIL %s win_ready_during_load got=%0b exp=0", tag, fw); end
        vectors++; if (starts != 1) begin miscompares++; $display("FAIL %s me_start_count got=%0d exp=1", tag, starts); end
        vectors++; if (start_at != NTOT) begin miscompares++; $display("FAIL %s me_start_after got=%0d exp=%0d", tag, start_at, NTOT); end
        vectors++; if (win_ready !== 1'b1) begin miscompares++; $display("FAIL %s win_ready got=%0b exp=1", tag, win_ready); end
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL %s pix_ready_after got=%0b exp=0", tag, pix_ready); end
    endtask

    task automatic test_pattern_reads();
        int ta[6] = '{5, 0, 2, 47, 15, 50};
        int ts[6] = '{0, 31, 32, 32, 7, 3};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            addr = 6'(ta[k]);
            amt  = 6'(ts[k]);
            @(posedge clk); #1;
            for (int l = 0; l < MD; l++) begin
                vectors++;
                if (cpr[l*8 +: 8] !== exp_cpr(ta[k], l)) begin
                    miscompares++;
                    $display("FAIL cpr addr=%0d lane=%0d got=%0d exp=%0d", ta[k], l, cpr[l*8 +: 8], exp_cpr(ta[k], l));
                end
            end
            for (int l = 0; l <= MD; l++) begin
                vectors++;
                if (spr[l*8 +: 8] !== exp_spr(ta[k], ts[k], l)) begin
                    miscompares++;
                    $display("FAIL spr addr=%0d amt=%0d lane=%0d got=%0d exp=%0d", ta[k], ts[k], l, spr[l*8 +: 8], exp_spr(ta[k], ts[k], l));
                end
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        int pa, ps;
        @(posedge clk); #1;
        pa = $urandom_range(0, 52); ps = $urandom_range(0, 36);
        addr = 6'(pa); amt = 6'(ps);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            for (int l = 0; l < MD; l++) begin
                vectors++;
                if (cpr[l*8 +: 8] !== exp_cpr(pa, l)) begin
                    miscompares++;
                    $display("FAIL b2b_cpr addr=%0d lane=%0d got=%0d exp=%0d", pa, l, cpr[l*8 +: 8], exp_cpr(pa, l));
                end
            end
            for (int l = 0; l <= MD; l++) begin
                vectors++;
                if (spr[l*8 +: 8] !== exp_spr(pa, ps, l)) begin
                    miscompares++;
                    $display("FAIL b2b_spr addr=%0d amt=%0d lane=%0d got=%0d exp=%0d", pa, ps, l, spr[l*8 +: 8], exp_spr(pa, ps, l));
                end
            end
            pa = $urandom_range(0, 52); ps = $urandom_range(0, 36);
            addr = 6'(pa); amt = 6'(ps);
        end
    endtask

    task automatic test_reset_mid_load();
        logic fr, fw;
        int starts, start_at, readies, kicks;
        bit tmo;
        run_load(1'b0, 1'b0, 1'b0, 400, fr, fw, starts, start_at, tmo);
        pix_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_pix_ready got=%0b exp=0", pix_ready); end
        vectors++; if (me_start !== 1'b0) begin miscompares++; $display("FAIL midrst_me_start got=%0b exp=0", me_start); end
        vectors++; if (win_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_win_ready got=%0b exp=0", win_ready); end
        vectors++; if (cpr !== '0) begin miscompares++; $display("FAIL midrst_cpr got=%0h exp=0", cpr); end
        vectors++; if (spr !== '0) begin miscompares++; $display("FAIL midrst_spr got=%0h exp=0", spr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        readies = 0; kicks = 0;
        for (int i = 0; i < 2600; i++) begin
            pix_in = 8'($urandom);
            @(posedge clk); #1;
            if (pix_ready) readies++;
            if (me_start) kicks++;
        end
        pix_valid = 1'b0;
        vectors++; if (readies != 0) begin miscompares++; $display("FAIL postrst_pix_ready_cycles got=%0d exp=0", readies); end
        vectors++; if (kicks != 0) begin miscompares++; $display("FAIL postrst_me_start got=%0d exp=0", kicks); end
        test_load("reload", 1'b0, 1'b0, 1'b0);
        test_back_to_back(40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load("pattern", 1'b0, 1'b1, 1'b0);
        test_pattern_reads();
        test_load("random", 1'b0, 1'b0, 1'b0);
        test_back_to_back(60);
        test_load("toggle", 1'b1, 1'b1, 1'b1);
        test_pattern_reads();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/me_window_loader.md
Name: me_window_loader

Overview:
- Upstream feeder for the motion-estimation core `me`.
- Accepts one current macroblock and its search window as a raster byte stream and stores them in column-banked on-chip memories.
- Pulses `me_start` once the load completes.
- Then serves the core's per-cycle row reads: MACRO_DIM current pixels on `pixel_cpr_out`, plus MACRO_DIM+1 horizontally offset search pixels on `pixel_spr_out`.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search window edge in pixels.
- Derived: NB = MACRO_DIM+1 = 17 search banks; NBAND = ceil(SEARCH_DIM/NB) = 3; search bank depth = NBAND*SEARCH_DIM = 144.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- load_start, input, 1, one-cycle request to begin a new load.
- pix_in, input, 8, stream pixel.
- pix_valid, input, 1, `pix_in` is valid.
- pix_ready, output, 1, block accepts `pix_in` this cycle.
- addr, input, 6, row index requested by `me`.
- amt, input, 6, horizontal search offset requested by `me` (0..SEARCH_DIM-MACRO_DIM).
- pixel_cpr_out, output, MACRO_DIM x 8, current-block row `addr`, columns 0..MACRO_DIM-1.
- pixel_spr_out, output, (MACRO_DIM+1) x 8, search row `addr`, columns amt..amt+MACRO_DIM.
- me_start, output, 1, one-cycle start pulse to `me`.
- win_ready, output, 1, window loaded and readable.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low.
- Reset values:
  - FSM goes to IDLE; all counters 0.
  - pix_ready=0, me_start=0, win_ready=0, pixel_cpr_out=0, pixel_spr_out=0.
  - Memory contents are not reset.
- FSM states: IDLE, LOAD_CUR, LOAD_SRCH, KICK, SERVE.
  - IDLE: on load_start, go to LOAD_CUR and clear the x/y counters.
  - LOAD_CUR:
    - pix_ready=1. A transfer occurs when pix_valid and pix_ready are both 1.
    - Pixel (x,y), raster order with x fastest, is written to cur bank x at address y.
    - After MACRO_DIM*MACRO_DIM transfers, go to LOAD_SRCH with counters cleared.
  - LOAD_SRCH:
    - pix_ready=1.
    - Pixel (x,y) is written to search bank x mod NB at address (x div NB)*SEARCH_DIM + y.
    - After SEARCH_DIM*SEARCH_DIM transfers, go to KICK. pix_ready drops in the cycle after the last transfer.
  - KICK: me_start=1 for exactly one cycle, then go to SERVE.
  - SERVE:
    - win_ready=1.
    - load_start returns the FSM to LOAD_CUR and drops win_ready in the next cycle.
- Ignored inputs:
  - load_start is ignored in LOAD_CUR, LOAD_SRCH and KICK.
  - pix_valid is ignored when pix_ready=0.
  - Gaps in pix_valid stall the counters; there is no timeout.
- Read path (all states; contents are meaningful only in SERVE):
  - Fixed 1-cycle registered latency: addr/amt sampled at edge N produce data after edge N+1.
  - pixel_cpr_out[l] = cur bank l, address addr.
  - For l = 0..MACRO_DIM, with column c = amt + l:
    - pixel_spr_out[l] = search bank (c mod NB), address (c div NB)*SEARCH_DIM + addr.
    - If c >= SEARCH_DIM or addr >= SEARCH_DIM, the output is 0.
  - Bank selection is a rotation: each bank supplies exactly one output lane per cycle. There is no port conflict.
- Writes and reads: write and read of the same bank address in one cycle returns the old data (read-first).
- Reset mid-load: all state is aborted. A subsequent load_start restarts from pixel 0; there is no partial me_start.

Test Plan:
- Load current pixel cur[y][x] = y*16+x and search pixel srch[y][x] = (y*48+x) mod 256 with pix_valid held 1 from load_start+1.
  - pix_ready is asserted the cycle after load_start.
  - After the 2560th accepted pixel, me_start pulses exactly once (KICK), then win_ready=1.
- SERVE, addr=5, amt=0: one cycle later, pixel_cpr_out[l] = 80+l; pixel_spr_out[l] = 240+l for l=0..15, and pixel_spr_out[16] = 0 (256 mod 256).
- amt=31, addr=0: pixel_spr_out[l] = 31+l for l=0..16 (columns 31..47; crosses banks 14,15,16,0..13).
- amt=32, addr=2: pixel_spr_out[l] = 128+l for l=0..15; pixel_spr_out[16] = 0 (column 48 is out of range).
- Load with pix_valid toggling 1,0,1,0…: the same stored data results, me_start arrives after exactly 2560 accepts, and load_start pulsed mid-load is ignored.
- rst_n low during LOAD_SRCH, then released:
  - All outputs are 0 and pix_ready=0.
  - No me_start occurs until a fresh load_start plus a full 2560-pixel load.
